mux_stream_rr: RTL and testbench



---
 rtl/mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/mux_stream_rr.sv | 146 ++++++++++++++
 tb/tb_mux_stream_rr.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the streaming multiplexer family.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Index width for a given channel count; never narrower than one bit.
    function automatic int sel_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: picks the first requester at or after the
// pointer and moves the pointer past the winner when told to advance.
// The lock input holds the pointer where it is on an advancing beat.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CH-1:0]                req,
    input  logic                             advance,
    input  logic                             lock,
    output logic [sel_width(NUM_CH)-1:0]     grant,
    output logic                             grant_valid
);

    localparam int SELW = sel_width(NUM_CH);

    logic [SELW-1:0] ptr;

    // Scan requests cyclically starting at the pointer; first hit wins.
    always_comb begin
        int idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_valid && req[idx]) begin
                grant       = SELW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner, wrapping at the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && !lock) begin
            ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel streaming multiplexer with a registered output stage.
// Selection is either a fixed external index or round-robin among valid
// channels. Define MUX_LOCK_EN to keep a channel granted until its
// in_last beat (packet lock); without it arbitration is per beat.
module mux_stream_rr
    import mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mode,
    input  logic [sel_width(NUM_CH)-1:0]  sel,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*WIDTH-1:0]       in_data,
    input  logic [NUM_CH-1:0]             in_last,
    output logic [NUM_CH-1:0]             in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [sel_width(NUM_CH)-1:0]  out_sel,
    input  logic                          out_ready
);

    localparam int SELW = sel_width(NUM_CH);

    mux_mode_e         mode_e;
    logic [NUM_CH-1:0] arb_req;
    logic [SELW-1:0]   arb_grant;
    logic              arb_grant_valid;
    logic              arb_hold;
    logic              locked;
    logic [SELW-1:0]   fix_grant;
    logic              fix_grant_valid;
    logic [SELW-1:0]   grant;
    logic              grant_valid;
    logic              load;
    logic [WIDTH-1:0]  grant_data;

    assign mode_e = mux_mode_e'(mode);

`ifdef MUX_LOCK_EN
    logic [SELW-1:0] lock_ch;

    // While locked only the locked channel may request the arbiter.
    always_comb begin
        arb_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_req[i] = in_valid[i] && (!locked || int'(lock_ch) == i);
        end
    end

    // Mid-packet beats keep the round-robin pointer parked.
    always_comb begin
        arb_hold = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(grant) == i) begin
                arb_hold = !in_last[i];
            end
        end
    end

    // Lock opens on a non-last beat and closes on the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (load) begin
            locked  <= arb_hold;
            lock_ch <= grant;
        end
    end
`else
    logic unused_last;

    assign unused_last = ^in_last;
    assign locked      = 1'b0;
    assign arb_req     = in_valid;
    assign arb_hold    = 1'b0;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (arb_req),
        .advance     (load && mode_e == MODE_RR),
        .lock        (arb_hold),
        .grant       (arb_grant),
        .grant_valid (arb_grant_valid)
    );

    // Fixed-mode pick: the selected channel if it exists and is valid.
    always_comb begin
        fix_grant       = sel;
        fix_grant_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(sel) == i) begin
                fix_grant_valid = in_valid[i];
            end
        end
    end

    // Mode mux; an open packet lock overrides mode and sel.
    always_comb begin
        if (locked || mode_e == MODE_RR) begin
            grant       = arb_grant;
            grant_valid = arb_grant_valid;
        end else begin
            grant       = fix_grant;
            grant_valid = fix_grant_valid;
        end
    end

    // Load when granted and the output register is empty or draining.
    assign load = rst_n && grant_valid && (!out_valid || out_ready);

    // Ready to the granted channel only, and data mux for the winner.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(grant) == i) begin
                in_ready[i] = load;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load replaces, otherwise drain empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: a cycle model predicts grants and
// pushes expected beats into a scoreboard that is popped on each output
// handshake. A second 3-channel instance covers an out-of-range sel.
module tb_mux_stream_rr;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [1:0] s;
        logic [7:0] d;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic [1:0]   sel = '0;
    logic [3:0]   in_valid = '0;
    logic [31:0]  in_data = 32'h13121110;
    logic [3:0]   in_last = 4'hF;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [7:0]   out_data;
    logic [1:0]   out_sel;
    logic         out_ready = 1'b0;

    logic [1:0]   sel3 = '0;
    logic [2:0]   valid3 = '0;
    logic [23:0]  data3 = 24'h323130;
    logic [2:0]   ready3;
    logic         ovalid3;
    logic [7:0]   odata3;
    logic [1:0]   osel3;

    int n_checks = 0;
    int n_errors = 0;

    beat_t sb[$];
    int    seen[$];

    logic       m_ov = 1'b0;
    logic [1:0] m_ptr = '0;
    logic       m_locked = 1'b0;
    logic [1:0] m_lock_ch = '0;

    always #5 clk = ~clk;

    mux_stream_rr #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    mux_stream_rr #(.WIDTH(W), .NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(sel3),
        .in_valid(valid3), .in_data(data3), .in_last(3'b111),
        .in_ready(ready3), .out_valid(ovalid3), .out_data(odata3),
        .out_sel(osel3), .out_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict, compare, advance model. Called at negedge.
    task automatic tick();
        logic       gv;
        logic [1:0] g;
        logic [1:0] idx;
        logic       ld;
        logic       hold;
        beat_t      b;
        #1;
        gv = 1'b0;
        g  = '0;
        if (m_locked) begin
            g  = m_lock_ch;
            gv = in_valid[m_lock_ch];
        end else if (mode) begin
            for (int k = 0; k < N; k++) begin
                idx = m_ptr + 2'(k);
                if (!gv && in_valid[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end else begin
            g  = sel;
            gv = in_valid[sel];
        end
        ld = rst_n && gv && (!m_ov || out_ready);
        check("in_ready", 32'(in_ready), ld ? 32'(4'b1 << g) : 32'h0);
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'h1);
            if (sb.size() > 0) begin
                b = sb.pop_front();
                check("out_data", 32'(out_data), 32'(b.d));
                check("out_sel", 32'(out_sel), 32'(b.s));
                seen.push_back(int'(out_sel));
            end
        end
        if (ld) begin
            b.s = g;
            b.d = in_data[g*8 +: 8];
            sb.push_back(b);
        end
        hold = 1'b0;
`ifdef MUX_LOCK_EN
        hold = !in_last[g];
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_ov = 1'b0;
            m_ptr = '0;
            m_locked = 1'b0;
        end else if (ld) begin
            m_ov = 1'b1;
            if (mode && !hold) m_ptr = g + 2'd1;
`ifdef MUX_LOCK_EN
            m_locked  = hold;
            m_lock_ch = g;
`endif
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_seen(input string tag, input int e0, input int e1, input int e2, input int e3);
        int exp[4];
        exp = '{e0, e1, e2, e3};
        check({tag, "_count"}, 32'(seen.size() >= 4), 32'h1);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) check(tag, 32'(seen[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        // Reset held with every channel valid
        mode = 1'b1;
        in_valid = 4'hF;
        out_ready = 1'b1;
        @(negedge clk);
        ticks(2);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        rst_n = 1'b1;

        // Round-robin, all valid: 0,1,2,3,0
        seen.delete();
        ticks(5);
        in_valid = 4'h0;
        tick();
        check_seen("rr_all", 0, 1, 2, 3);
        if (seen.size() >= 5) check("rr_all_wrap", 32'(seen[4]), 32'h0);

        // Round-robin, ch1 and ch3 only: 1,3,1,3
        seen.delete();
        in_valid = 4'b1010;
        ticks(5);
        in_valid = 4'h0;
        tick();
        check_seen("rr_odd", 1, 3, 1, 3);

        // Fixed mode sel=2
        mode = 1'b0;
        sel = 2'd2;
        in_valid = 4'hF;
        ticks(4);
        check("fix_data", 32'(out_data), 32'h12);
        check("fix_sel", 32'(out_sel), 32'h2);
        in_valid = 4'h0;
        tick();

        // Backpressure on ch0
        sel = 2'd0;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        in_data[7:0] = 8'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_data", 32'(out_data), 32'h10);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        check("bp_no_gap", 32'(out_valid), 32'h1);
        check("bp_next_data", 32'(out_data), 32'h20);
        in_valid = 4'h0;
        tick();
        in_data[7:0] = 8'h10;

        // Fixed-mode miss and out-of-range sel
        sel = 2'd1;
        in_valid = 4'b1101;
        tick();
        check("miss_ready", 32'(in_ready), 32'h0);
        check("miss_valid", 32'(out_valid), 32'h0);
        in_valid = 4'h0;
        valid3 = 3'b111;
        sel3 = 2'd3;
        #1;
        check("oor_ready", 32'(ready3), 32'h0);
        tick();
        check("oor_valid", 32'(ovalid3), 32'h0);
        sel3 = 2'd2;
        #1;
        check("n3_ready", 32'(ready3), 32'h4);
        tick();
        check("n3_valid", 32'(ovalid3), 32'h1);
        check("n3_sel", 32'(osel3), 32'h2);
        check("n3_data", 32'(odata3), 32'h32);
        valid3 = 3'b000;

        // Reset mid-transfer discards the held beat
        mode = 1'b1;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        tick();
        in_valid = 4'h0;
        check("mid_loaded", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_data", 32'(out_data), 32'h0);
        sb.delete();
        m_ov = 1'b0;
        m_ptr = '0;
        m_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

`ifdef MUX_LOCK_EN
        // Packet lock on ch2 over three beats, then ch3
        in_valid = 4'b0010;
        tick();
        in_valid = 4'h0;
        tick();
        seen.delete();
        in_valid = 4'b1101;
        in_last = 4'b1011;
        ticks(2);
        in_last = 4'hF;
        ticks(2);
        in_valid = 4'h0;
        tick();
        check_seen("lock", 2, 2, 2, 3);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom_range(0, 15));
            in_last   = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 4'h0;
        out_ready = 1'b1;
        in_last   = 4'hF;
        ticks(3);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
